// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder and its load path.
package dmem_pkg;

  // Width of the wait-state counter (WAIT_STATES range 0..15).
  localparam int DMEM_WS_W = 4;

  // Access size encoding as presented on req_size.
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } dmem_size_e;

  // Request-level FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // A request is in error when the size is illegal or the address is not
  // naturally aligned for the access size.
  function automatic logic dmem_req_err(input dmem_size_e size, input logic [1:0] off);
    logic err;
    unique case (size)
      SZ_B:    err = 1'b0;
      SZ_H:    err = off[0];
      SZ_W:    err = (off != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Combinational load formatter: picks the addressed byte/halfword out of a
// little-endian 32-bit word and sign- or zero-extends it.
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  dmem_size_e  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  // Align the addressed lane to bit 0, then extend according to size.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    shifted = word_i >> {offset_i, 3'b000};
    data_o  = '0;
    unique case (size_i)
      SZ_B:    data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      SZ_H:    data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      SZ_W:    data_o = word_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder with configurable wait states, byte-lane
// stores, extended loads and alignment/size error reporting.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int WAIT_STATES    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err
);

  localparam int MEM_BYTES = 1 << MEM_ADDR_WIDTH;
  localparam logic [DMEM_WS_W-1:0] WS_INIT = DMEM_WS_W'(WAIT_STATES);

  // Upper address bits are deliberately ignored: the store wraps.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[ADDRESS_WIDTH-1:MEM_ADDR_WIDTH];

  dmem_state_e            state_q, state_d;
  logic [DMEM_WS_W-1:0]   cnt_q, cnt_d;
  logic                   capture, access;

  // Captured request.
  logic                      we_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  dmem_size_e                size_q;
  logic                      uns_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic                      err_q;

  // Registered response.
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rsp_err_q;

  // Byte storage and the per-lane write path.
  logic [7:0]                mem_q [MEM_BYTES];
  logic [MEM_ADDR_WIDTH-3:0] word_base;
  logic [31:0]               rd_word;
  logic [31:0]               ld_data;
  logic [3:0]                be_base, be;
  logic [DATA_WIDTH-1:0]     wdata_sh;
  logic                      wr_en;

  // Next-state logic: accept in IDLE, count down wait states in BUSY, pulse in RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          cnt_d   = WS_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          access  = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);

  // FSM state and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture, including the alignment/size error decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else if (capture) begin
      we_q    <= req_we;
      addr_q  <= req_addr[MEM_ADDR_WIDTH-1:0];
      size_q  <= dmem_size_e'(req_size);
      uns_q   <= req_unsigned;
      wdata_q <= req_wdata;
      err_q   <= dmem_req_err(dmem_size_e'(req_size), req_addr[1:0]);
    end
  end

  // Word-granular read of the containing aligned word, then lane select/extend.
  assign word_base = addr_q[MEM_ADDR_WIDTH-1:2];
  assign rd_word   = {mem_q[{word_base, 2'd3}], mem_q[{word_base, 2'd2}],
                      mem_q[{word_base, 2'd1}], mem_q[{word_base, 2'd0}]};

  dmem_load_ext u_load_ext (
    .word_i     (rd_word),
    .offset_i   (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ld_data)
  );

  // Byte enables and lane-aligned store data for the addressed bytes.
  always_comb begin
    be_base = 4'b0000;
    unique case (size_q)
      SZ_B:    be_base = 4'b0001;
      SZ_H:    be_base = 4'b0011;
      SZ_W:    be_base = 4'b1111;
      default: be_base = 4'b0000;
    endcase
    be       = be_base << addr_q[1:0];
    wdata_sh = wdata_q << {addr_q[1:0], 3'b000};
    wr_en    = access & we_q & ~err_q;
    rdata_d  = (we_q | err_q) ? '0 : ld_data;
  end

  // Storage write port with one enable per byte lane.
  always_ff @(posedge clk) begin
    // NOTE: the memory array has no reset; only the control path does, and it
    // gates every write, so stale contents are harmless.
    for (int i = 0; i < 4; i++) begin
      if (wr_en && be[i]) begin
        mem_q[{word_base, 2'(i)}] <= wdata_sh[8*i +: 8];
      end
    end
  end

  // Response data/error, updated only at the access edge and held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q   <= '0;
      rsp_err_q <= 1'b0;
    end else if (access) begin
      rdata_q   <= rdata_d;
      rsp_err_q <= err_q;
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised self-checking bench for dmem_responder against a byte-array model.
module tb_dmem_responder;

  localparam int WS  = 2;
  localparam int MAW = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mem_m [256];

  always #5 clk = ~clk;

  dmem_responder #(
    .ADDRESS_WIDTH  (32),
    .DATA_WIDTH     (32),
    .MEM_ADDR_WIDTH (MAW),
    .WAIT_STATES    (WS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  // Behavioural reference: alignment rules, little-endian byte array, extension.
  function automatic void model_access(input logic we, input logic [31:0] addr,
                                       input logic [1:0] size, input logic uns,
                                       input logic [31:0] wdata,
                                       output logic [31:0] rd, output logic err);
    int n;
    int base;
    logic [31:0] v;
    err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
    rd  = '0;
    if (err) return;
    n    = 1 << size;
    base = int'(addr[7:0]);
    if (we) begin
      for (int i = 0; i < n; i++) mem_m[(base + i) % 256] = wdata[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(mem_m[(base + i) % 256]) << (8 * i));
      if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      rd = v;
    end
  endfunction

  // Drive one request at the next free slot and collect its response.
  // lat counts negedges after the accepting edge; -1 means no response seen.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic err, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rd  = rsp_rdata;
    err = rsp_err;
    if (!rsp_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0)
      $display("FAIL reset: ready=%b valid=%b rdata=%h err=%b, need 1 0 00000000 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Store random words over the whole array so every later load is defined.
  task automatic test_fill();
    logic [31:0] rd, erd, wd;
    logic        err, eerr;
    int          lat;
    for (int w = 0; w < 64; w++) begin
      wd = $urandom;
      model_access(1'b1, 32'(w * 4), 2'd2, 1'b0, wd, erd, eerr);
      issue(1'b1, 32'(w * 4), 2'd2, 1'b0, wd, rd, err, lat);
      n_checks++;
      if (rd !== erd || err !== eerr || lat != WS + 2)
        $display("FAIL fill[%0d]: rdata=%h err=%b lat=%0d, need %h %b %0d",
                 w, rd, err, lat, erd, eerr, WS + 2);
      else n_pass++;
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic        known;
    logic [31:0] exp;
    logic        exp_err;
  } dir_t;

  task automatic test_directed();
    dir_t        tbl[$];
    logic [31:0] rd, erd;
    logic        err, eerr;
    int          lat;
    tbl.push_back('{1'b1, 32'h10,  2'd2, 1'b0, 32'h12345678, 1'b1, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 32'h10,  2'd2, 1'b0, 32'h0,        1'b1, 32'h12345678, 1'b0});
    tbl.push_back('{1'b0, 32'h13,  2'd0, 1'b0, 32'h0,        1'b1, 32'h00000012, 1'b0});
    tbl.push_back('{1'b1, 32'h21,  2'd0, 1'b0, 32'hAAAAAA80, 1'b1, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 32'h21,  2'd0, 1'b0, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0});
    tbl.push_back('{1'b0, 32'h21,  2'd0, 1'b1, 32'h0,        1'b1, 32'h00000080, 1'b0});
    tbl.push_back('{1'b0, 32'h20,  2'd0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 32'h30,  2'd1, 1'b0, 32'h5555BEEF, 1'b1, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 32'h30,  2'd1, 1'b0, 32'h0,        1'b1, 32'hFFFFBEEF, 1'b0});
    tbl.push_back('{1'b0, 32'h30,  2'd1, 1'b1, 32'h0,        1'b1, 32'h0000BEEF, 1'b0});
    tbl.push_back('{1'b0, 32'h30,  2'd2, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 32'h02,  2'd2, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1});
    tbl.push_back('{1'b0, 32'h04,  2'd3, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1});
    tbl.push_back('{1'b1, 32'h06,  2'd2, 1'b0, 32'hDEADDEAD, 1'b1, 32'h0,        1'b1});
    tbl.push_back('{1'b0, 32'h04,  2'd2, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 32'h08,  2'd2, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 32'h104, 2'd2, 1'b0, 32'hCAFEF00D, 1'b1, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 32'h04,  2'd2, 1'b0, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0});
    foreach (tbl[k]) begin
      model_access(tbl[k].we, tbl[k].addr, tbl[k].size, tbl[k].uns, tbl[k].wdata, erd, eerr);
      if (tbl[k].known) begin
        erd  = tbl[k].exp;
        eerr = tbl[k].exp_err;
      end
      issue(tbl[k].we, tbl[k].addr, tbl[k].size, tbl[k].uns, tbl[k].wdata, rd, err, lat);
      n_checks++;
      if (rd !== erd || err !== eerr || lat != WS + 2)
        $display("FAIL directed[%0d] addr=%h: rdata=%h err=%b lat=%0d, need %h %b %0d",
                 k, tbl[k].addr, rd, err, lat, erd, eerr, WS + 2);
      else n_pass++;
    end
  endtask

  // A second request pulsed while BUSY must be ignored, not queued.
  task automatic test_busy_ignore();
    logic [31:0] rd, erd;
    logic        err, eerr;
    int          lat;
    int          extra;
    model_access(1'b1, 32'h50, 2'd2, 1'b0, 32'hA5A5_0001, erd, eerr);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h50; req_size = 2'd2;
    req_unsigned = 1'b0; req_wdata = 32'hA5A5_0001;
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h54; req_wdata = 32'h5A5A_0002;
    n_checks++;
    if (req_ready !== 1'b0) $display("FAIL busy_ready: req_ready=%b, need 0", req_ready);
    else n_pass++;
    lat = 1;
    @(negedge clk);
    req_valid = 1'b0;
    lat++;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != WS + 2 || rsp_err !== 1'b0)
      $display("FAIL busy_latency: lat=%0d err=%b, need %0d 0", lat, rsp_err, WS + 2);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL busy_after_resp: valid=%b ready=%b, need 0 1", rsp_valid, req_ready);
    else n_pass++;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) extra++;
    end
    n_checks++;
    if (extra != 0) $display("FAIL busy_no_extra: %0d extra responses, need 0", extra);
    else n_pass++;
    model_access(1'b0, 32'h50, 2'd2, 1'b0, 32'h0, erd, eerr);
    issue(1'b0, 32'h50, 2'd2, 1'b0, 32'h0, rd, err, lat);
    n_checks++;
    if (rd !== 32'hA5A5_0001 || err !== 1'b0)
      $display("FAIL busy_first_kept: rdata=%h err=%b, need a5a50001 0", rd, err);
    else n_pass++;
    model_access(1'b0, 32'h54, 2'd2, 1'b0, 32'h0, erd, eerr);
    issue(1'b0, 32'h54, 2'd2, 1'b0, 32'h0, rd, err, lat);
    n_checks++;
    if (rd !== erd || err !== eerr)
      $display("FAIL busy_second_dropped: rdata=%h err=%b, need %h %b", rd, err, erd, eerr);
    else n_pass++;
  endtask

  // Reset during the wait states of a store aborts it cleanly.
  task automatic test_reset_mid();
    logic [31:0] rd, erd;
    logic        err, eerr;
    int          lat;
    int          seen;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_size = 2'd2;
    req_unsigned = 1'b0; req_wdata = 32'h0BAD_0BAD;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL reset_mid_idle: ready=%b valid=%b, need 1 0", req_ready, rsp_valid);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL reset_mid_no_resp: %0d responses, need 0", seen);
    else n_pass++;
    model_access(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, erd, eerr);
    issue(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, rd, err, lat);
    n_checks++;
    if (rd !== erd || err !== eerr || lat != WS + 2)
      $display("FAIL reset_mid_old_data: rdata=%h err=%b lat=%0d, need %h %b %0d",
               rd, err, lat, erd, eerr, WS + 2);
    else n_pass++;
  endtask

  // Random mix of sizes, signedness and (mostly aligned) wrapping addresses.
  task automatic test_random();
    logic [31:0] rd, erd, addr, wd;
    logic        err, eerr, we, uns;
    logic [1:0]  size;
    int          lat;
    for (int k = 0; k < 160; k++) begin
      we   = ($urandom_range(0, 2) == 0);
      size = 2'($urandom_range(0, 9) < 9 ? $urandom_range(0, 2) : 3);
      uns  = 1'($urandom);
      wd   = $urandom;
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
      model_access(we, addr, size, uns, wd, erd, eerr);
      issue(we, addr, size, uns, wd, rd, err, lat);
      n_checks++;
      if (rd !== erd || err !== eerr || lat != WS + 2)
        $display("FAIL random[%0d] we=%b addr=%h size=%0d uns=%b: rdata=%h err=%b lat=%0d, need %h %b %0d",
                 k, we, addr, size, uns, rd, err, lat, erd, eerr, WS + 2);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_directed();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

endmodule
